isa_host_sequencer: RTL and testbench

//  Hardware host for the compute-core register interface: drives the control/data words and reads the status word that the

---
 rtl/isa_host_sequencer_pkg.sv | 39 +++
 rtl/isa_host_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_isa_host_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_host_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : isa_host_pkg                                                |
// | Shared state encoding and register-word bit positions for the        |
// | compute-core host sequencer.                                          |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package isa_host_pkg;

  // Sequencer states; ABORT is the core-reset tail after a watchdog timeout
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    WCLR  = 3'd4,
    START = 3'd5,
    WAIT  = 3'd6,
    ABORT = 3'd7
  } state_t;

  // control_low_word bit positions
  localparam int CTL_WEA    = 14;
  localparam int CTL_ISA    = 15;
  localparam int CTL_GRANT  = 16;
  // control_high_word bit positions
  localparam int HI_RST     = 0;
  localparam int HI_START   = 1;
  // status word bit positions
  localparam int ST_DONE    = 0;
  localparam int ST_CNT_LSB = 2;

  localparam int ISA_SLOTS  = 16;
  localparam int INS_W      = 42;
  localparam int SLOT_W     = $clog2(ISA_SLOTS);

endpackage
`default_nettype wire

// File: rtl/isa_host_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : isa_host_sequencer                                          |
// | Resets the compute core, writes 1..16 ISA instructions through the   |
// | register interface, pulses start, polls done and returns the core    |
// | cycle count. Watchdog aborts a run that never completes.             |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module isa_host_sequencer
  import isa_host_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int STATUS_LAG = 2,
  parameter int TIMEOUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [4:0]        prog_len,
  output logic              ins_req,
  output logic [3:0]        ins_addr,
  input  logic [INS_W-1:0]  ins_data,
  input  logic              ins_valid,
  output logic [31:0]       control_low_word,
  output logic [31:0]       control_high_word,
  output logic [31:0]       dina_ext_low_word,
  output logic [31:0]       dina_ext_high_word,
  input  logic [31:0]       status,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [29:0]       cycle_count
);

  localparam int RC_W  = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam int LAG_W = (STATUS_LAG < 2) ? 1 : $clog2(STATUS_LAG + 1);

  state_t                 state, state_n;
  logic [SLOT_W-1:0]      slot, slot_n;
  logic [SLOT_W-1:0]      last_slot, last_slot_n;
  logic [RC_W-1:0]        rcnt, rcnt_n;
  logic [LAG_W-1:0]       lag, lag_n;
  logic [TIMEOUT_W-1:0]   wdog, wdog_n, wdog_inc;
  logic [INS_W-1:0]       ins_q, ins_q_n;
  logic                   core_rst, core_rst_n;
  logic                   core_start, core_start_n;
  logic                   wea, wea_n;
  logic                   isa_sel, isa_sel_n;
  logic                   req_n, busy_n, done_n, err_n;
  logic [29:0]            count_n;
  logic                   len_ok;

  // status[1] carries no information for the sequencer
  logic unused_status_bit;
  assign unused_status_bit = status[1];

  assign len_ok   = (prog_len != 5'd0) && (prog_len <= 5'(ISA_SLOTS));
  assign wdog_inc = wdog + 1'b1;
  assign ins_addr = slot;

  assign dina_ext_low_word  = ins_q[31:0];
  assign dina_ext_high_word = {22'd0, ins_q[INS_W-1:32]};

  // Pack the register words from their registered fields; grant and bram_sel stay 0
  always_comb begin
    control_low_word                = '0;
    control_low_word[SLOT_W-1:0]    = slot;
    control_low_word[CTL_WEA]       = wea;
    control_low_word[CTL_ISA]       = isa_sel;
    control_low_word[CTL_GRANT]     = 1'b0;
    control_high_word               = '0;
    control_high_word[HI_RST]       = core_rst;
    control_high_word[HI_START]     = core_start;
  end

  // Next-state and next-output decode; pulses default low, everything else holds
  always_comb begin
    state_n      = state;
    slot_n       = slot;
    last_slot_n  = last_slot;
    rcnt_n       = rcnt;
    lag_n        = lag;
    wdog_n       = wdog;
    ins_q_n      = ins_q;
    core_rst_n   = core_rst;
    core_start_n = 1'b0;
    wea_n        = 1'b0;
    isa_sel_n    = isa_sel;
    req_n        = ins_req;
    busy_n       = busy;
    done_n       = 1'b0;
    err_n        = 1'b0;
    count_n      = cycle_count;
    case (state)
      IDLE: begin
        if (go) begin
          if (len_ok) begin
            last_slot_n = SLOT_W'(prog_len - 5'd1);
            slot_n      = '0;
            rcnt_n      = '0;
            core_rst_n  = 1'b1;
            busy_n      = 1'b1;
            state_n     = RESET;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RESET: begin
        if (rcnt == RC_W'(RST_CYCLES - 1)) begin
          rcnt_n     = '0;
          core_rst_n = 1'b0;
          req_n      = 1'b1;
          state_n    = FETCH;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      FETCH: begin
        if (ins_valid) begin
          ins_q_n   = ins_data;
          req_n     = 1'b0;
          wea_n     = 1'b1;
          isa_sel_n = 1'b1;
          state_n   = WRITE;
        end
      end
      WRITE: begin
        state_n = WCLR;
      end
      WCLR: begin
        isa_sel_n = 1'b0;
        if (slot == last_slot) begin
          core_start_n = 1'b1;
          state_n      = START;
        end else begin
          slot_n  = slot + 1'b1;
          req_n   = 1'b1;
          state_n = FETCH;
        end
      end
      START: begin
        lag_n   = LAG_W'(STATUS_LAG);
        wdog_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (lag != '0) begin
          lag_n = lag - 1'b1;
        end
        // done takes precedence over a watchdog expiry in the same cycle
        if ((lag == '0) && status[ST_DONE]) begin
          count_n = status[31:ST_CNT_LSB];
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (&wdog_inc) begin
          wdog_n     = wdog_inc;
          err_n      = 1'b1;
          busy_n     = 1'b0;
          core_rst_n = 1'b1;
          rcnt_n     = '0;
          state_n    = ABORT;
        end else begin
          wdog_n = wdog_inc;
        end
      end
      ABORT: begin
        if (rcnt == RC_W'(RST_CYCLES - 1)) begin
          rcnt_n     = '0;
          core_rst_n = 1'b0;
          state_n    = IDLE;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      last_slot   <= '0;
      rcnt        <= '0;
      lag         <= '0;
      wdog        <= '0;
      ins_q       <= '0;
      core_rst    <= 1'b0;
      core_start  <= 1'b0;
      wea         <= 1'b0;
      isa_sel     <= 1'b0;
      ins_req     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      last_slot   <= last_slot_n;
      rcnt        <= rcnt_n;
      lag         <= lag_n;
      wdog        <= wdog_n;
      ins_q       <= ins_q_n;
      core_rst    <= core_rst_n;
      core_start  <= core_start_n;
      wea         <= wea_n;
      isa_sel     <= isa_sel_n;
      ins_req     <= req_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      cycle_count <= count_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isa_host_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_isa_host_sequencer                                       |
// | Scoreboard bench: stimulus queues the expected register-interface    |
// | events of each run, a monitor pops and compares them as they appear. |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_isa_host_sequencer;
  import isa_host_pkg::*;

  localparam int RST_C = 4;
  localparam int LAG   = 2;
  localparam int TW    = 6;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [4:0]  prog_len;
  logic        ins_req, ins_valid;
  logic [3:0]  ins_addr;
  logic [41:0] ins_data;
  logic [31:0] control_low_word, control_high_word, dina_ext_low_word, dina_ext_high_word;
  logic [31:0] status;
  logic        busy, done, err;
  logic [29:0] cycle_count;

  isa_host_sequencer #(.RST_CYCLES(RST_C), .STATUS_LAG(LAG), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .go(go), .prog_len(prog_len),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_data(ins_data), .ins_valid(ins_valid),
    .control_low_word(control_low_word), .control_high_word(control_high_word),
    .dina_ext_low_word(dina_ext_low_word), .dina_ext_high_word(dina_ext_high_word),
    .status(status), .busy(busy), .done(done), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef enum {EV_WRITE, EV_START, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          addr;
    logic [41:0] data;
    logic [29:0] cnt;
    int          lat;
    bit          was_busy;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0, bad = 0;
  int          cyc = 0, fin = 0;
  logic [41:0] prog [16];
  int          src_min = 1, src_max = 1;
  int          core_d = 1;
  bit          core_never = 1'b0;
  logic [29:0] core_cnt = '0;
  logic [29:0] last_count = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic ev_t mk_ev(ev_kind_t k, int a, logic [41:0] d, logic [29:0] c, int l, bit wb);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cnt = c; e.lat = l; e.was_busy = wb;
    return e;
  endfunction

  task automatic pop_expect(input ev_kind_t k, output ev_t e, output bit ok);
    total++;
    ok = 1'b0;
    e  = mk_ev(k, 0, '0, '0, -1, 1'b0);
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event_order: got=%s want=<none>", k.name());
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        bad++;
        $display("FAIL event_order: got=%s want=%s", k.name(), e.kind.name());
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Program source: one-cycle ins_valid reply after a random latency
  initial begin
    int lat;
    ins_valid = 1'b0;
    ins_data  = '0;
    forever begin
      @(posedge clk); #1;
      ins_valid = 1'b0;
      if (ins_req && !rst) begin
        lat = $urandom_range(src_max, src_min);
        repeat (lat) begin @(posedge clk); #1; end
        ins_data  = prog[ins_addr];
        ins_valid = 1'b1;
      end
    end
  end

  // Core model: raises done with a count core_d cycles after the start pulse
  initial begin
    int cd;
    cd     = -1;
    status = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || control_high_word[HI_RST]) begin
        status = '0; cd = -1;
      end else if (control_high_word[HI_START]) begin
        status = '0; cd = core_never ? -1 : core_d;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) status = {core_cnt, 1'b0, 1'b1};
      end
    end
  end

  // Monitor: pops the scoreboard on every visible event and checks pulse widths
  int   wea_run = 0, st_run = 0, hi0_run = 0;
  int   last_wea_cyc = -1, start_cyc = 0;
  bit   busy_prev = 1'b0;
  ev_t  mon_e;
  bit   mon_ok;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      wea_run = 0; st_run = 0; hi0_run = 0; busy_prev = 1'b0;
    end else begin
      if (control_low_word[CTL_WEA]) begin
        if (wea_run == 0) begin
          pop_expect(EV_WRITE, mon_e, mon_ok);
          if (mon_ok) begin
            chk("wr_addr", control_low_word[13:0], mon_e.addr);
            chk("wr_isa_sel", control_low_word[CTL_ISA], 1);
            chk("wr_reserved", {control_low_word[31:29], control_low_word[CTL_GRANT]}, 0);
            chk("wr_dina_lo", dina_ext_low_word, mon_e.data[31:0]);
            chk("wr_dina_hi", dina_ext_high_word, {22'd0, mon_e.data[41:32]});
            if (last_wea_cyc >= 0) chk("wr_gap_ge3", (cyc - last_wea_cyc) >= 3, 1);
          end
          last_wea_cyc = cyc;
        end
        wea_run++;
      end else begin
        if (wea_run != 0) chk("wea_width", wea_run, 1);
        wea_run = 0;
      end

      if (control_high_word[HI_START]) begin
        if (st_run == 0) begin
          pop_expect(EV_START, mon_e, mon_ok);
          chk("start_hi_word", control_high_word, 32'h2);
          start_cyc = cyc;
        end
        st_run++;
      end else begin
        if (st_run != 0) chk("start_width", st_run, 1);
        st_run = 0;
      end

      if (done) begin
        pop_expect(EV_DONE, mon_e, mon_ok);
        if (mon_ok) begin
          chk("done_count", cycle_count, mon_e.cnt);
          chk("done_latency", cyc - start_cyc, mon_e.lat);
          last_count = mon_e.cnt;
        end
        chk("done_busy", busy, 0);
        chk("done_busy_prev", busy_prev, 1);
        chk("done_no_err", err, 0);
        fin++;
      end

      if (err) begin
        pop_expect(EV_ERR, mon_e, mon_ok);
        if (mon_ok) begin
          chk("err_busy_prev", busy_prev, mon_e.was_busy);
          chk("err_core_rst", control_high_word[HI_RST], mon_e.was_busy);
          if (mon_e.lat >= 0) chk("err_latency", cyc - start_cyc, mon_e.lat);
        end
        chk("err_busy", busy, 0);
        chk("err_count_held", cycle_count, last_count);
        fin++;
      end

      if (control_high_word[HI_RST]) begin
        hi0_run++;
      end else begin
        if (hi0_run != 0) chk("core_rst_width", hi0_run, RST_C);
        hi0_run = 0;
      end
      busy_prev = busy;
    end
  end

  // One run: fill program, queue expected events, pulse go, wait bounded for done/err
  task automatic do_run(input int len, input int d, input bit never, input int smin,
                        input int smax, input bit go_again, input bit fixed);
    logic [63:0]  r;
    logic [29:0]  cnt;
    logic [127:0] snap;
    int           fin0;
    bit           legal;
    last_wea_cyc = -1;
    src_min = smin; src_max = smax; core_d = d; core_never = never;
    r = {$urandom(), $urandom()};
    cnt = fixed ? 30'd1234 : r[29:0];
    core_cnt = cnt;
    for (int i = 0; i < 16; i++) begin
      r = {$urandom(), $urandom()};
      prog[i] = fixed ? (42'h300_0000_0000 + 42'(i + 1)) : r[41:0];
    end
    legal = (len >= 1) && (len <= 16);
    if (legal) begin
      for (int i = 0; i < len; i++) exp_q.push_back(mk_ev(EV_WRITE, i, prog[i], '0, -1, 1'b0));
      exp_q.push_back(mk_ev(EV_START, 0, '0, '0, -1, 1'b0));
      if (never) exp_q.push_back(mk_ev(EV_ERR, 0, '0, '0, 1 + ((1 << TW) - 1), 1'b1));
      else exp_q.push_back(mk_ev(EV_DONE, 0, '0, cnt, 1 + (((LAG + 1) > d) ? (LAG + 1) : d), 1'b0));
    end else begin
      exp_q.push_back(mk_ev(EV_ERR, 0, '0, '0, -1, 1'b0));
    end
    snap = {control_low_word, control_high_word, dina_ext_low_word, dina_ext_high_word};
    fin0 = fin;
    @(posedge clk); #1;
    prog_len = 5'(len);
    go = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      go = go_again && (k == 12) && busy;
      if (go) prog_len = 5'($urandom_range(16, 1));
      if (fin != fin0) break;
    end
    go = 1'b0;
    chk("run_finished", fin != fin0, 1);
    if (!legal) begin
      chk("illegal_words_held", {control_low_word, control_high_word, dina_ext_low_word, dina_ext_high_word}, snap);
      chk("illegal_busy_low", busy, 0);
    end
    repeat (RST_C + 3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ins_req"}, ins_req, 0);
    chk({tag, "_ins_addr"}, ins_addr, 0);
    chk({tag, "_low_word"}, control_low_word, 0);
    chk({tag, "_high_word"}, control_high_word, 0);
    chk({tag, "_dina_lo"}, dina_ext_low_word, 0);
    chk({tag, "_dina_hi"}, dina_ext_high_word, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // Reset in the middle of a 16-instruction load while slot 5 is being fetched
  task automatic rst_midrun();
    logic [63:0] r;
    bit          hit;
    hit = 1'b0;
    src_min = 3; src_max = 5; core_d = 2; core_never = 1'b0;
    last_wea_cyc = -1;
    for (int i = 0; i < 16; i++) begin
      r = {$urandom(), $urandom()};
      prog[i] = r[41:0];
      exp_q.push_back(mk_ev(EV_WRITE, i, prog[i], '0, -1, 1'b0));
    end
    @(posedge clk); #1;
    prog_len = 5'd16;
    go = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      go = 1'b0;
      if (ins_req && ins_addr == 4'd5) begin hit = 1'b1; break; end
    end
    chk("reach_fetch_slot5", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrun_rst");
    exp_q.delete();
    last_count = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; prog_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    do_run(3, 1, 1'b0, 1, 1, 1'b0, 1'b1);
    do_run(0, 1, 1'b0, 1, 1, 1'b0, 1'b0);
    do_run(17, 1, 1'b0, 1, 1, 1'b0, 1'b0);
    do_run(2, 1, 1'b1, 1, 3, 1'b0, 1'b0);
    rst_midrun();
    do_run(16, 3, 1'b0, 1, 10, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      do_run($urandom_range(16, 1), $urandom_range(8, 1), 1'b0, 1, 10, (t % 2) == 1, 1'b0);
    end
    do_run(1, 5, 1'b0, 1, 2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
